// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions: multiply/divide opcodes and unit FSM states.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } muldiv_state_t;

  // Signed variants take operand magnitudes and need a final sign fix.
  function automatic logic is_signed_op(muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// CPU <-> multiply/divide unit bus: request, direct HI/LO writes, status, results.
interface mips_muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b, mthi, mtlo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, mthi, mtlo, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mips_signfix.sv
// Conditional two's-complement negation, used for operand magnitudes and result signs.
module mips_signfix #(
  parameter int N = 32
) (
  input  logic [N-1:0] value,
  input  logic         negate,
  output logic [N-1:0] result
);

  assign result = negate ? ((~value) + N'(1)) : value;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: one bit per cycle, magnitudes in the core
// loop, a single FIX cycle applies signs and writes HI/LO.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  mips_muldiv_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  muldiv_state_t      state, state_next;
  logic [CW-1:0]      cnt;
  muldiv_op_t         op_q;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  // Operand magnitudes; unsigned ops pass the raw value through.
  logic             op_signed, neg_a, neg_b;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign op_signed = is_signed_op(bus.op);
  assign neg_a     = op_signed & bus.op_a[WIDTH-1];
  assign neg_b     = op_signed & bus.op_b[WIDTH-1];

  mips_signfix #(.N(WIDTH)) u_abs_a (.value(bus.op_a), .negate(neg_a), .result(a_mag_in));
  mips_signfix #(.N(WIDTH)) u_abs_b (.value(bus.op_b), .negate(neg_b), .result(b_mag_in));

  // Next-state logic: WIDTH iterations in MUL/DIV, then a single FIX cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE:        if (bus.start) state_next = is_div_op(bus.op) ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (cnt == CW'(WIDTH - 1)) state_next = ST_FIX;
      ST_FIX:         state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // Shared WIDTH+1 adder: shift-add for multiply, trial subtract for restoring divide.
  logic [WIDTH:0]       rem_shift, add_x, add_y, add_sum;
  logic                 add_sub, q_bit;
  logic [2*WIDTH-1:0]   acc_step;

  // One iteration of the active algorithm over the accumulator.
  always_comb begin
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    add_sub   = (state == ST_DIV);
    add_x     = add_sub ? rem_shift : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y     = (add_sub || acc[0]) ? {1'b0, b_mag} : '0;
    add_sum   = add_x + (add_sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, add_sub};
    q_bit     = ~add_sum[WIDTH];
    if (add_sub)
      acc_step = {(q_bit ? add_sum[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], q_bit};
    else
      acc_step = {add_sum, acc[WIDTH-1:1]};
  end

  // Result sign correction: product by sign XOR, quotient likewise, remainder follows dividend.
  logic               div_zero, prod_neg, quot_neg, rem_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign div_zero = (b_mag == '0);
  assign prod_neg = (op_q == OP_MULT) & (sign_a ^ sign_b);
  assign quot_neg = (op_q == OP_DIV) & (sign_a ^ sign_b) & ~div_zero;
  assign rem_neg  = (op_q == OP_DIV) & sign_a;

  mips_signfix #(.N(2*WIDTH)) u_fix_prod (.value(acc), .negate(prod_neg), .result(prod));
  mips_signfix #(.N(WIDTH))   u_fix_quot (.value(acc[WIDTH-1:0]), .negate(quot_neg), .result(quot));
  mips_signfix #(.N(WIDTH))   u_fix_rem  (.value(acc[2*WIDTH-1:WIDTH]), .negate(rem_neg), .result(rem));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset)          state <= ST_IDLE;
    else if (clk_enable) state <= state_next;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_mag  <= '0;
      acc    <= '0;
    end else if (clk_enable) begin
      unique case (state)
        ST_IDLE: if (bus.start) begin
          op_q   <= bus.op;
          sign_a <= neg_a;
          sign_b <= neg_b;
          b_mag  <= b_mag_in;
          acc    <= {{WIDTH{1'b0}}, a_mag_in};
          cnt    <= '0;
        end
        ST_MUL, ST_DIV: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Architectural HI/LO plus the done / divide-by-zero pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (state == ST_FIX) begin
        done_q <= 1'b1;
        if (is_div_op(op_q)) begin
          dbz_q <= div_zero;
          hi_q  <= rem;
          lo_q  <= div_zero ? {WIDTH{1'b1}} : quot;
        end else begin
          {hi_q, lo_q} <= prod;
        end
      end else if (state == ST_IDLE && !bus.start) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit at WIDTH = 32: a vector table of
// single operations plus hand-written multi-cycle sequences.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b1;

  mips_muldiv_unit_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request for one edge, then scramble operands to prove they were latched.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = muldiv_op_t'($urandom_range(0, 3));
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int dones;
    logic [31:0] got_hi, got_lo;

    vecs[0]  = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_m3x7",    OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{"div_m7d2",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"divu_5d0",     OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{"div_minneg",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"mult_m1xm1",   OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[6]  = '{"divu_100d7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7]  = '{"div_7dm2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{"multu_shift",  OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[9]  = '{"div_m8d0",     OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{"mult_minsq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[11] = '{"divu_maxd1",   OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{"mult_maxxm1",  OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};

    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;

    // Reset state.
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz",  bus.div_by_zero, 0);
    check("rst_hi",   bus.hi, 0);
    check("rst_lo",   bus.lo, 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Direct HI/LO writes, independent and simultaneous, held by clk_enable.
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("mt_both_hi", bus.hi, 32'hA5A5A5A5);
    check("mt_both_lo", bus.lo, 32'hA5A5A5A5);
    bus.mtlo = 1'b0; bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    check("mthi_hi", bus.hi, 32'h12345678);
    check("mthi_lo", bus.lo, 32'hA5A5A5A5);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h0BADF00D;
    clk_enable = 1'b0;
    @(posedge clk); #1;
    check("mtlo_hold", bus.lo, 32'hA5A5A5A5);
    clk_enable = 1'b1;
    @(posedge clk); #1;
    check("mtlo_lo", bus.lo, 32'h0BADF00D);
    check("mtlo_hi", bus.hi, 32'h12345678);
    bus.mtlo = 1'b0;

    // Table of single operations.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, bus.busy, 1);
      wait_done(n);
      check({vecs[i].name, "_lat"}, n, LAT);
      check({vecs[i].name, "_hi"},  bus.hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"},  bus.lo, vecs[i].exp_lo);
      check({vecs[i].name, "_dbz"}, bus.div_by_zero, vecs[i].exp_dbz);
      check({vecs[i].name, "_busy_at_done"}, bus.busy, 0);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, bus.done, 0);
      check({vecs[i].name, "_dbz_pulse"},  bus.div_by_zero, 0);
    end

    // Start re-pulsed at cycle 5 and mthi at cycle 6 of a MULTU are ignored.
    issue(OP_MULTU, 32'd1000, 32'd3000);
    dones = 0; got_hi = 'x; got_lo = 'x;
    for (int c = 1; c <= 60; c++) begin
      bus.start = (c == 5);
      bus.op    = OP_DIVU;
      bus.mthi  = (c == 6);
      bus.wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        got_hi = bus.hi;
        got_lo = bus.lo;
      end
    end
    bus.start = 1'b0; bus.mthi = 1'b0;
    check("repulse_dones", dones, 1);
    check("repulse_hi", got_hi, 32'h00000000);
    check("repulse_lo", got_lo, 32'h002DC6C0);
    check("repulse_hi_end", bus.hi, 32'h00000000);
    check("repulse_lo_end", bus.lo, 32'h002DC6C0);

    // clk_enable low for 5 cycles mid-DIVU stretches latency by 5.
    issue(OP_DIVU, 32'd1000, 32'd7);
    n = 0;
    for (int c = 1; c <= 200; c++) begin
      clk_enable = !(c >= 10 && c < 15);
      @(posedge clk); #1;
      if (bus.done) begin
        n = c;
        break;
      end
    end
    clk_enable = 1'b1;
    check("stall_lat", n, LAT + 5);
    check("stall_hi", bus.hi, 32'd6);
    check("stall_lo", bus.lo, 32'd142);

    // Reset at cycle 10 of a MULTU clears immediately; a fresh op then works.
    @(posedge clk); #1;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_hi",   bus.hi, 0);
    check("midrst_lo",   bus.lo, 0);
    check("midrst_done", bus.done, 0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done(n);
    check("postrst_lat", n, LAT);
    check("postrst_hi", bus.hi, 32'd0);
    check("postrst_lo", bus.lo, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are 8 to 64, even.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port clk_enable, input, 1 bit: when low, all registers hold.
REQ-005 The block SHALL have port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have port op_a, input, WIDTH bits: rs operand (multiplicand or dividend).
REQ-008 The block SHALL have port op_b, input, WIDTH bits: rt operand (multiplier or divisor).
REQ-009 The block SHALL have ports mthi and mtlo, input, 1 bit each: direct write strobes for HI and LO.
REQ-010 The block SHALL have port wdata, input, WIDTH bits: data for mthi/mtlo.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-012 The block SHALL have port done, output, 1 bit: registered single-enabled-cycle completion pulse.
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: qualifies done for a divide with op_b = 0.
REQ-014 The block SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI and LO registers.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV and FIX; the reset state is IDLE.
REQ-016 In IDLE with start = 1, the block SHALL latch op, |op_a| and |op_b| (raw values for unsigned ops) plus the operand sign bits, and go to MUL or DIV.
REQ-017 Operand changes after the start edge SHALL be ignored.
REQ-018 MUL and DIV SHALL each run exactly WIDTH enabled cycles, one bit per cycle (shift-add multiply; restoring divide), counted by a counter of $clog2(WIDTH)+1 bits; the block then enters FIX.
REQ-019 FIX SHALL take one cycle: apply sign correction, write hi/lo, set done = 1, return to IDLE.
REQ-020 Latency: hi/lo/done SHALL update on the (WIDTH+1)th enabled edge after the edge that samples start.
REQ-021 busy SHALL be high from the edge after the start sample until the edge that raises done; busy and done SHALL never both be high.
REQ-022 MULT and MULTU SHALL produce the 2*WIDTH-bit product, with HI = upper half and LO = lower half.
REQ-023 For MULT, the product SHALL be negated if the operand signs differ.
REQ-024 DIV and DIVU SHALL produce LO = quotient and HI = remainder.
REQ-025 For DIV, the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the dividend's sign (truncation toward zero).
REQ-026 Divide by zero SHALL give the same latency, HI = op_a, LO = all ones, and div_by_zero = 1 with done.
REQ-027 DIV of the most-negative value by -1 SHALL give LO = the most-negative value and HI = 0, with no flag.
REQ-028 start while busy SHALL be ignored, with no queueing.
REQ-029 mthi/mtlo in IDLE SHALL write wdata on the next enabled edge.
REQ-030 mthi/mtlo while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-031 mthi and mtlo SHALL be independent of each other and may both be asserted in one cycle.
REQ-032 With clk_enable low, the FSM, counter, hi/lo and done SHALL all hold, stretching latency by the number of disabled cycles.

Reset
REQ-033 While reset is low, the block SHALL immediately force state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0 and div_by_zero = 0, regardless of clk_enable.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no partial result; the first start after release SHALL execute normally.

Structure
REQ-035 Package mips_pkg SHALL hold muldiv_op_t (the 2-bit op enum) and muldiv_state_t; the CPU and this block share it.
REQ-036 One combinational sub-module, mips_signfix, SHALL perform conditional two's-complement negation, instanced for operand magnitudes and for result correction.
REQ-037 No other sub-modules are permitted; the datapath is a 2*WIDTH-bit shift register plus a WIDTH+1-bit adder/subtractor.

Verification (WIDTH = 32)
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001, done on the 33rd edge after the start sample.
REQ-039 MULT -3 x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-040 DIVU 5 / 0 -> hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1 for the done cycle only; DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-041 start re-pulsed at cycle 5 of a MULTU, plus mthi at cycle 6 -> the original result is unchanged and no second done occurs.
REQ-042 clk_enable low for 5 cycles mid-DIVU -> done arrives 5 cycles later and the result is unchanged.
REQ-043 reset driven low at cycle 10 of a MULTU -> busy, hi and lo go to 0 without a clock edge; a fresh MULTU 6 x 7 then gives lo = 42.
